// File: rtl/matmul_feeder.sv
// Buffers row-major A and B operand streams, then replays them in lockstep
// to a downstream matmul and waits for it to return to idle.
module matmul_feeder #(
  parameter int BUF_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [63:0] cfg_dims_a,
  input  logic [63:0] cfg_dims_b,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_data,
  output logic        mm_start,
  output logic [63:0] mm_dims_a,
  output logic [63:0] mm_dims_b,
  output logic [31:0] mm_in_a,
  output logic [31:0] mm_in_b,
  input  logic [31:0] mm_state,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = (BUF_SIZE > 2) ? $clog2(BUF_SIZE) : 1;
  localparam logic signed [31:0] LIM = 32'(BUF_SIZE);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, STREAM, WAIT, REJECT
  } state_t;

  state_t state, nxt;

  logic [31:0]   buf_a [BUF_SIZE];
  logic [31:0]   buf_b [BUF_SIZE];
  logic [63:0]   dims_a, dims_b;
  logic [AW-1:0] cnt_a, cnt_b;
  logic [AW-1:0] idx_a, idx_b, k;
  logic [AW-1:0] na, nb, s_len, last_k;
  logic          fire_a, fire_b;

  logic signed [31:0] ra, ca, rb, cb, pa, pb;
  logic               bad;

  assign ra = cfg_dims_a[63:32];
  assign ca = cfg_dims_a[31:0];
  assign rb = cfg_dims_b[63:32];
  assign cb = cfg_dims_b[31:0];
  assign pa = ra * ca;
  assign pb = rb * cb;

  // Per-dim bounds keep the 32-bit products from wrapping into range.
  assign bad = (ra <= 0) || (ca <= 0) || (rb <= 0) || (cb <= 0) ||
               (ca != rb) ||
               (ra >= LIM) || (ca >= LIM) ||
               (rb >= LIM) || (cb >= LIM) ||
               (pa >= LIM) || (pb >= LIM);

  assign s_len  = (cnt_a > cnt_b) ? cnt_a : cnt_b;
  assign last_k = s_len - AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dims_a <= '0;
      dims_b <= '0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      idx_a  <= '0;
      idx_b  <= '0;
      k      <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (cfg_valid && !bad) begin
            dims_a <= cfg_dims_a;
            dims_b <= cfg_dims_b;
            cnt_a  <= pa[AW-1:0];
            cnt_b  <= pb[AW-1:0];
            idx_a  <= '0;
            idx_b  <= '0;
          end
        end
        LOAD: begin
          idx_a <= na;
          idx_b <= nb;
        end
        START:   k <= '0;
        STREAM:  k <= k + AW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fire_a) buf_a[idx_a] <= a_data;
    if (fire_b) buf_b[idx_b] <= b_data;
  end

  always_comb begin
    nxt       = state;
    cfg_ready = 1'b0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    mm_start  = 1'b0;
    mm_dims_a = '0;
    mm_dims_b = '0;
    mm_in_a   = '0;
    mm_in_b   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    fire_a    = 1'b0;
    fire_b    = 1'b0;
    na        = idx_a;
    nb        = idx_b;
    unique case (state)
      IDLE: begin
        cfg_ready = !rst;
        if (cfg_valid) nxt = bad ? REJECT : LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        a_ready = idx_a < cnt_a;
        b_ready = idx_b < cnt_b;
        fire_a  = a_valid && a_ready;
        fire_b  = b_valid && b_ready;
        na      = idx_a + AW'(fire_a);
        nb      = idx_b + AW'(fire_b);
        if (na == cnt_a && nb == cnt_b) nxt = START;
      end
      START: begin
        busy      = 1'b1;
        mm_start  = 1'b1;
        mm_dims_a = dims_a;
        mm_dims_b = dims_b;
        nxt       = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        mm_dims_a = dims_a;
        mm_dims_b = dims_b;
        if (k < cnt_a) mm_in_a = buf_a[k];
        if (k < cnt_b) mm_in_b = buf_b[k];
        if (k == last_k) nxt = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        mm_dims_a = dims_a;
        mm_dims_b = dims_b;
        if (mm_state == 32'd0) begin
          done = 1'b1;
          nxt  = IDLE;
        end
      end
      REJECT: begin
        err = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: doc/matmul_feeder.md
MATMUL_FEEDER -- requirements
Module: matmul_feeder

Interface
REQ-001 SHALL have parameter BUF_SIZE, default 1024, per-operand element capacity; a configuration is legal only if its element count is < BUF_SIZE.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1), cfg_dims_a and cfg_dims_b (input, 64 each), carrying the matmul_dims_t {rows, cols} fields as 32-bit signed ints.
REQ-005 SHALL have ports a_valid (input, 1), a_ready (output, 1), a_data (input, 32): the row-major element stream for A.
REQ-006 SHALL have ports b_valid (input, 1), b_ready (output, 1), b_data (input, 32): the row-major element stream for B.
REQ-007 SHALL have ports mm_start (output, 1), mm_dims_a and mm_dims_b (output, 64 each), mm_in_a and mm_in_b (output, 32 each), which drive the downstream matmul.
REQ-008 SHALL have port mm_state, input, 32 bits: the matmul state, encoded IDLE=0, READ=1, CALCULATE=2, WRITE=3, ERROR=4.
REQ-009 SHALL have outputs busy (1), done (1) and err (1).

Function
REQ-010 SHALL implement the states IDLE, LOAD, START, STREAM, WAIT and REJECT.
REQ-011 SHALL drive cfg_ready=1 only in IDLE; a transfer occurs on a clock edge where cfg_valid and cfg_ready are both 1.
REQ-012 On a transfer, SHALL capture both dims and compute cnt_a = rows_a*cols_a and cnt_b = rows_b*cols_b.
REQ-013 SHALL reject the transfer if any dim is <= 0, or cols_a != rows_b, or cnt_a >= BUF_SIZE, or cnt_b >= BUF_SIZE; a rejected transfer moves to REJECT, otherwise to LOAD with idx_a = idx_b = 0.
REQ-014 REJECT SHALL last exactly one cycle with err=1, then return to IDLE; no buffer contents change.
REQ-015 In LOAD, a_ready SHALL be (idx_a < cnt_a), combinational from state and counter; b_ready likewise for B; both are 0 in all other states.
REQ-016 Each a_valid&a_ready edge SHALL write a_data to buf_a[idx_a] and increment idx_a; B is handled identically and independently.
REQ-017 LOAD SHALL move to START on the edge at which both counts are complete, counting a final transfer made on that same edge.
REQ-018 START SHALL last exactly one cycle with mm_start=1; mm_start SHALL be 0 in every other state.
REQ-019 mm_dims_a and mm_dims_b SHALL equal the captured dims from START until the return to IDLE, and SHALL be 0 in IDLE.
REQ-020 STREAM SHALL last S = max(cnt_a, cnt_b) cycles.
REQ-021 In STREAM cycle k (k = 0..S-1), mm_in_a SHALL be buf_a[k] if k < cnt_a, else 0; mm_in_b follows the same rule with buf_b and cnt_b.
REQ-022 mm_in_a and mm_in_b SHALL be 0 outside STREAM.
REQ-023 After the last STREAM cycle, the block SHALL enter WAIT.
REQ-024 WAIT SHALL exit on the first edge where mm_state == 0 (IDLE); on that exit, done=1 for exactly one cycle, then the block returns to IDLE.
REQ-025 busy SHALL be 1 in LOAD, START, STREAM and WAIT, and 0 in IDLE and REJECT.
REQ-026 cfg_valid outside IDLE SHALL be ignored, with no state change.
REQ-027 The product arithmetic SHALL be 32-bit signed; BUF_SIZE <= 2^15 guarantees no overflow once REQ-013 checks pass.
REQ-028 Element data SHALL be passed through unmodified, 32 bits, with no arithmetic on it.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, all counters=0, and every output 0 except cfg_ready, which is 1 once rst deasserts.
REQ-030 Reset in any state SHALL abandon the operation; buffer contents need not be cleared.
REQ-031 The first cfg transfer SHALL be possible on the first edge after rst deasserts.

Verification
REQ-032 2x2*2x2 config, A=1,2,3,4 and B=5,6,7,8 with continuous valid -> START 4 cycles after cfg (cycle after last data edge), mm_start single pulse, STREAM shows pairs (1,5) (2,6) (3,7) (4,8), then WAIT; bench forcing mm_state=0 -> done pulse, back to IDLE.
REQ-033 2x3*3x1, A=1..6, B=7,8,9 -> 6 STREAM cycles, mm_in_b = 7,8,9,0,0,0.
REQ-034 cols_a=3, rows_b=2 -> err=1 for one cycle, a_ready and b_ready never 1, cfg_ready again 1 the next cycle.
REQ-035 2x2*2x2 with a_valid toggling every other cycle and b continuous -> b_ready drops after 4 B transfers, START only after the 4th A transfer, stream data identical to REQ-032.
REQ-036 rst asserted mid-LOAD after 2 A elements -> outputs 0 immediately (asynchronous), IDLE afterwards; a fresh 1x1*1x1 transaction (A=3, B=4) then completes, streaming (3,4).
REQ-037 cfg_valid pulsed during STREAM with different dims -> ignored; mm_dims unchanged until done.
